wmst_ctrl: RTL and testbench
============================

WMST_CTRL -- requirements
Module: wmst_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, meaning internal word-count/length width.
REQ-002 SHALL have parameter DW, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DATA_SIZE, default 1024, meaning total words to store per job (0..2^AW).
REQ-004 SHALL have parameter TILE_LEN, default 128, meaning maximum words per burst (1..2^AW-1).
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port store_start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 SHALL have port store_done, output, 1 bit: one-cycle pulse at job completion.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port param_waddr, output, DW bits: byte write address of the current burst.
REQ-011 SHALL have port param_iolen, output, AW bits: word length of the current burst.
REQ-012 SHALL have port store_trans_start, output, 1 bit: one-cycle burst launch pulse to the write master.
REQ-013 SHALL have port store_trans_done, input, 1 bit: burst-complete pulse from the write master.
REQ-014 SHALL have port store_fifo_count, input, AW+1 bits: words currently held in the outgoing result FIFO.

Function
REQ-015 SHALL implement states IDLE, WAIT, CONFIG, TRANS, DONE, FINISH.
REQ-016 In IDLE with store_start=1, SHALL load remaining length len (AW+1 bits) with DATA_SIZE and param_waddr with 0, then go to WAIT; with DATA_SIZE=0 it SHALL go straight to FINISH.
REQ-017 In WAIT, tile = min(len, TILE_LEN); SHALL go to CONFIG only when store_fifo_count >= tile, otherwise stay in WAIT.
REQ-018 In CONFIG (exactly one cycle), SHALL register param_iolen <= tile and go to TRANS.
REQ-019 store_trans_start SHALL be high for exactly the first TRANS cycle, with param_waddr and param_iolen already valid and held stable through TRANS.
REQ-020 In TRANS, SHALL go to DONE on store_trans_done=1, including a done in the same cycle as store_trans_start.
REQ-021 In DONE (one cycle), SHALL set len <= len - param_iolen and param_waddr <= param_waddr + (param_iolen << 2), modulo 2^DW.
REQ-022 From DONE, SHALL go to FINISH if the updated len is 0, else to WAIT.
REQ-023 In FINISH, SHALL assert store_done for exactly one cycle and return to IDLE; busy SHALL be low from the cycle after FINISH.
REQ-024 SHALL ignore store_start outside IDLE and store_trans_done outside TRANS.
REQ-025 All outputs SHALL be registered; store_done and store_trans_start SHALL never be asserted together.

Reset
REQ-026 On rst=1, SHALL immediately force state IDLE, store_done=0, store_trans_start=0, busy=0, param_waddr=0, param_iolen=0 and len=0, including mid-burst.
REQ-027 After rst is released, the first store_start SHALL begin a fresh job at address 0.

Configuration
REQ-028 With macro WMST_STALL_CNT_EN defined, SHALL add output stall_cycles (32 bits) counting cycles spent in WAIT, cleared to 0 when a job is accepted, saturating at all-ones, reset to 0.
REQ-029 Without WMST_STALL_CNT_EN, stall_cycles and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-030 State encodings and the default TILE_LEN SHALL live in shared package wmst_pkg.
REQ-031 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-032 DATA_SIZE=300, TILE_LEN=128, fifo_count held at 512 -> three bursts (iolen 128/128/44, waddr 0/512/1024), then one store_done pulse.
REQ-033 DATA_SIZE=128, fifo_count=100 for 20 cycles then 128 -> no store_trans_start while count < 128; then one burst (iolen 128); stall_cycles=20 when macro enabled.
REQ-034 store_start pulsed mid-job and store_trans_done pulsed in WAIT -> no state, address or length change.
REQ-035 rst asserted in TRANS of the second burst -> all outputs 0 at once; next job restarts at waddr 0 with iolen 128.
REQ-036 DATA_SIZE=0 -> store_done pulse with no store_trans_start.
REQ-037 store_trans_done coincident with store_trans_start -> DONE on the next cycle with correct address/length update.

Source files
------------

// File: rtl/wmst_pkg.sv
// Shared definitions for the result write-master controller: state encoding
// and the default burst (tile) length.
package wmst_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CONFIG = 3'd2,
    S_TRANS  = 3'd3,
    S_DONE   = 3'd4,
    S_FINISH = 3'd5
  } wmst_state_t;

  localparam int TILE_LEN_DEF = 128;

endpackage

// File: rtl/wmst_ctrl.sv
// Write-master controller: splits a DATA_SIZE-word store job into bursts of at
// most TILE_LEN words, launching each burst only once the outgoing FIFO holds
// enough words, and advancing the byte address by 4 bytes per word.
// Optional feature: define WMST_STALL_CNT_EN to add the stall_cycles output,
// which counts cycles spent waiting on the FIFO during the current job.
module wmst_ctrl
  import wmst_pkg::*;
#(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024,
  parameter int TILE_LEN  = TILE_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_start,
  output logic          store_done,
  output logic          busy,
  output logic [DW-1:0] param_waddr,
  output logic [AW-1:0] param_iolen,
  output logic          store_trans_start,
  input  logic          store_trans_done,
  input  logic [AW:0]   store_fifo_count
`ifdef WMST_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam logic [AW:0] LP_SIZE = (AW+1)'(DATA_SIZE);
  localparam logic [AW:0] LP_TILE = (AW+1)'(TILE_LEN);

  wmst_state_t r_state;
  wmst_state_t w_next;
  logic [AW:0] r_len;
  logic [AW:0] w_tile;
  logic [AW:0] w_len_sub;
  logic        w_fifo_ok;
  logic        w_accept;

  // Burst size and readiness derived from the remaining length.
  always_comb begin
    w_tile    = (r_len > LP_TILE) ? LP_TILE : r_len;
    w_len_sub = r_len - {1'b0, param_iolen};
    w_fifo_ok = (store_fifo_count >= w_tile);
    w_accept  = (r_state == S_IDLE) && store_start;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (store_start) w_next = (LP_SIZE == '0) ? S_FINISH : S_WAIT;
      S_WAIT:   if (w_fifo_ok) w_next = S_CONFIG;
      S_CONFIG: w_next = S_TRANS;
      S_TRANS:  if (store_trans_done) w_next = S_DONE;
      S_DONE:   w_next = (w_len_sub == '0) ? S_FINISH : S_WAIT;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register plus registered outputs; flag outputs are decoded from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_len             <= '0;
      param_waddr       <= '0;
      param_iolen       <= '0;
      busy              <= 1'b0;
      store_done        <= 1'b0;
      store_trans_start <= 1'b0;
    end else begin
      r_state           <= w_next;
      busy              <= (w_next != S_IDLE);
      store_done        <= (w_next == S_FINISH);
      store_trans_start <= (r_state == S_CONFIG);
      case (r_state)
        S_IDLE: if (store_start) begin
          r_len       <= LP_SIZE;
          param_waddr <= '0;
        end
        S_CONFIG: param_iolen <= w_tile[AW-1:0];
        S_DONE: begin
          r_len       <= w_len_sub;
          param_waddr <= param_waddr + DW'({param_iolen, 2'b00});
        end
        default: ;
      endcase
    end
  end

`ifdef WMST_STALL_CNT_EN
  // Saturating count of FIFO-wait cycles, restarted for each accepted job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (w_accept)
      stall_cycles <= '0;
    else if ((r_state == S_WAIT) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_wmst_ctrl.sv
// Directed bench for wmst_ctrl. Three instances share clock, reset and inputs:
// A (300 words), B (128 words), C (0 words); each test checks its own instance.
module tb_wmst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tdone = 1'b0;
  logic [12:0] fifo = '0;

  logic        a_done, a_busy, a_ts;
  logic [31:0] a_waddr;
  logic [11:0] a_iolen;
  logic        b_done, b_busy, b_ts;
  logic [31:0] b_waddr;
  logic [11:0] b_iolen;
  logic        c_done, c_busy, c_ts;
  logic [31:0] c_waddr;
  logic [11:0] c_iolen;
`ifdef WMST_STALL_CNT_EN
  logic [31:0] a_stall, b_stall, c_stall;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int a_ts_cnt = 0, a_done_cnt = 0, b_ts_cnt = 0, b_done_cnt = 0, c_ts_cnt = 0;
  int ovl = 0;

  always #5 clk = ~clk;

  wmst_ctrl #(.DATA_SIZE(300), .TILE_LEN(128)) u_a (
    .clk(clk), .rst(rst), .store_start(start), .store_done(a_done), .busy(a_busy),
    .param_waddr(a_waddr), .param_iolen(a_iolen), .store_trans_start(a_ts),
    .store_trans_done(tdone), .store_fifo_count(fifo)
`ifdef WMST_STALL_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  wmst_ctrl #(.DATA_SIZE(128), .TILE_LEN(128)) u_b (
    .clk(clk), .rst(rst), .store_start(start), .store_done(b_done), .busy(b_busy),
    .param_waddr(b_waddr), .param_iolen(b_iolen), .store_trans_start(b_ts),
    .store_trans_done(tdone), .store_fifo_count(fifo)
`ifdef WMST_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  wmst_ctrl #(.DATA_SIZE(0), .TILE_LEN(128)) u_c (
    .clk(clk), .rst(rst), .store_start(start), .store_done(c_done), .busy(c_busy),
    .param_waddr(c_waddr), .param_iolen(c_iolen), .store_trans_start(c_ts),
    .store_trans_done(tdone), .store_fifo_count(fifo)
`ifdef WMST_STALL_CNT_EN
    , .stall_cycles(c_stall)
`endif
  );

  // pulse counters and done/start overlap detector
  always @(posedge clk) begin
    if (a_ts)   a_ts_cnt   <= a_ts_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_ts)   b_ts_cnt   <= b_ts_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (c_ts)   c_ts_cnt   <= c_ts_cnt + 1;
    if ((a_ts && a_done) || (b_ts && b_done) || (c_ts && c_done)) ovl <= ovl + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; tdone = 1'b0; fifo = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_ts(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 && a_ts) || (which == 1 && b_ts)) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_done(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 && a_done) || (which == 1 && b_done)) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_chk++;
    if ({a_busy, a_done, a_ts, a_waddr, a_iolen} !== '0) begin
      n_fail++; $display("FAIL reset_a got %b/%b/%b %0d %0d want all 0", a_busy, a_done, a_ts, a_waddr, a_iolen);
    end
    n_chk++;
    if ({b_busy, b_done, b_ts, b_waddr, b_iolen, c_busy, c_done, c_ts, c_waddr, c_iolen} !== '0) begin
      n_fail++; $display("FAIL reset_bc got nonzero outputs want all 0");
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_multi_burst();
    int exp_len[3] = '{128, 128, 44};
    int ts0, d0;
    bit ok;
    do_reset();
    ts0 = a_ts_cnt; d0 = a_done_cnt;
    fifo = 13'd512;
    start = 1'b1; step(); start = 1'b0;
    n_chk++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy got %b want 1", a_busy); end
    for (int b = 0; b < 3; b++) begin
      wait_ts(0, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL multi_ts_timeout burst %0d", b); break; end
      n_chk++;
      if (a_iolen !== 12'(exp_len[b]) || a_waddr !== 32'(b * 512)) begin
        n_fail++; $display("FAIL multi_param burst %0d got iolen %0d waddr %0d want %0d %0d", b, a_iolen, a_waddr, exp_len[b], b * 512);
      end
      step(); step();
      n_chk++;
      if (a_ts !== 1'b0 || a_iolen !== 12'(exp_len[b]) || a_waddr !== 32'(b * 512)) begin
        n_fail++; $display("FAIL multi_hold burst %0d got ts %b iolen %0d waddr %0d", b, a_ts, a_iolen, a_waddr);
      end
      tdone = 1'b1; step(); tdone = 1'b0;
    end
    wait_done(0, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL multi_done_timeout"); end
    n_chk++;
    if (a_waddr !== 32'd1200) begin n_fail++; $display("FAIL multi_final_waddr got %0d want 1200", a_waddr); end
    step();
    n_chk++;
    if (a_ts_cnt - ts0 != 3 || a_done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL multi_counts got ts %0d done %0d want 3 1", a_ts_cnt - ts0, a_done_cnt - d0);
    end
    n_chk++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL multi_idle got busy %b done %b want 0 0", a_busy, a_done);
    end
  endtask

  task automatic test_coincident();
    int exp_len[3] = '{128, 128, 44};
    int exp_wa[3]  = '{512, 1024, 1200};
    int old_wa;
    bit ok;
    do_reset();
    fifo = 13'd512;
    start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wait_ts(0, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL coin_ts_timeout burst %0d", b); break; end
      n_chk++;
      if (a_iolen !== 12'(exp_len[b])) begin
        n_fail++; $display("FAIL coin_iolen burst %0d got %0d want %0d", b, a_iolen, exp_len[b]);
      end
      old_wa = (b == 0) ? 0 : exp_wa[b-1];
      tdone = 1'b1; step(); tdone = 1'b0;
      n_chk++;
      if (a_ts !== 1'b0 || a_waddr !== 32'(old_wa)) begin
        n_fail++; $display("FAIL coin_done_cycle burst %0d got ts %b waddr %0d want 0 %0d", b, a_ts, a_waddr, old_wa);
      end
      step();
      n_chk++;
      if (a_waddr !== 32'(exp_wa[b]) || a_done !== (b == 2)) begin
        n_fail++; $display("FAIL coin_update burst %0d got waddr %0d done %b want %0d %b", b, a_waddr, a_done, exp_wa[b], b == 2);
      end
    end
  endtask

  task automatic test_ignore();
    int ts0;
    bit ok;
    do_reset();
    fifo = 13'd512;
    start = 1'b1; step(); start = 1'b0;
    wait_ts(0, ok);
    step();
    tdone = 1'b1; fifo = 13'd0; step(); tdone = 1'b0;
    step(); step();
    ts0 = a_ts_cnt;
    start = 1'b1; step(); start = 1'b0;
    tdone = 1'b1; step(); tdone = 1'b0;
    step(); step();
    n_chk++;
    if (a_waddr !== 32'd512 || a_iolen !== 12'd128 || a_busy !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL ignore_state got waddr %0d iolen %0d busy %b done %b want 512 128 1 0", a_waddr, a_iolen, a_busy, a_done);
    end
    n_chk++;
    if (a_ts_cnt != ts0) begin n_fail++; $display("FAIL ignore_no_ts got %0d launches want 0", a_ts_cnt - ts0); end
    fifo = 13'd512;
    wait_ts(0, ok);
    n_chk++;
    if (!ok || a_waddr !== 32'd512 || a_iolen !== 12'd128) begin
      n_fail++; $display("FAIL ignore_resume got ok %b waddr %0d iolen %0d want 1 512 128", ok, a_waddr, a_iolen);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    fifo = 13'd512;
    start = 1'b1; step(); start = 1'b0;
    wait_ts(0, ok);
    tdone = 1'b1; step(); tdone = 1'b0;
    wait_ts(0, ok);
    n_chk++;
    if (!ok || a_waddr !== 32'd512) begin n_fail++; $display("FAIL rmid_second got ok %b waddr %0d want 1 512", ok, a_waddr); end
    rst = 1'b1; #1;
    n_chk++;
    if ({a_busy, a_done, a_ts, a_waddr, a_iolen} !== '0) begin
      n_fail++; $display("FAIL rmid_async got %b/%b/%b %0d %0d want all 0", a_busy, a_done, a_ts, a_waddr, a_iolen);
    end
    step();
    rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_ts(0, ok);
    n_chk++;
    if (!ok || a_waddr !== 32'd0 || a_iolen !== 12'd128) begin
      n_fail++; $display("FAIL rmid_restart got ok %b waddr %0d iolen %0d want 1 0 128", ok, a_waddr, a_iolen);
    end
  endtask

  task automatic test_stall();
    int ts0, d0;
    bit ok;
    do_reset();
    fifo = 13'd100;
    ts0 = b_ts_cnt; d0 = b_done_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    n_chk++;
    if (b_ts_cnt != ts0 || b_ts !== 1'b0 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_no_launch got launches %0d busy %b want 0 1", b_ts_cnt - ts0, b_busy);
    end
    fifo = 13'd128;
    wait_ts(1, ok);
    n_chk++;
    if (!ok || b_iolen !== 12'd128 || b_waddr !== 32'd0) begin
      n_fail++; $display("FAIL stall_burst got ok %b iolen %0d waddr %0d want 1 128 0", ok, b_iolen, b_waddr);
    end
    step();
    tdone = 1'b1; step(); tdone = 1'b0;
    wait_done(1, ok);
    step();
    n_chk++;
    if (!ok || b_done_cnt - d0 != 1 || b_ts_cnt - ts0 != 1) begin
      n_fail++; $display("FAIL stall_done got ok %b done %0d ts %0d want 1 1 1", ok, b_done_cnt - d0, b_ts_cnt - ts0);
    end
`ifdef WMST_STALL_CNT_EN
    n_chk++;
    if (b_stall !== 32'd20) begin n_fail++; $display("FAIL stall_count got %0d want 20", b_stall); end
`endif
  endtask

  task automatic test_zero();
    int ts0;
    do_reset();
    ts0 = c_ts_cnt;
    fifo = 13'd512;
    start = 1'b1; step(); start = 1'b0;
    n_chk++;
    if (c_done !== 1'b1 || c_busy !== 1'b1 || c_ts !== 1'b0) begin
      n_fail++; $display("FAIL zero_finish got done %b busy %b ts %b want 1 1 0", c_done, c_busy, c_ts);
    end
    step();
    n_chk++;
    if (c_done !== 1'b0 || c_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle got done %b busy %b want 0 0", c_done, c_busy);
    end
    step();
    n_chk++;
    if (c_ts_cnt != ts0) begin n_fail++; $display("FAIL zero_no_ts got %0d launches want 0", c_ts_cnt - ts0); end
  endtask

  task automatic test_exclusive();
    n_chk++;
    if (ovl != 0) begin n_fail++; $display("FAIL exclusive got %0d overlaps want 0", ovl); end
  endtask

  initial begin
    test_reset();
    test_multi_burst();
    test_coincident();
    test_ignore();
    test_reset_mid();
    test_stall();
    test_zero();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
